// File: rtl/iperf_client_hls_deadlock_monitor_unit.sv
`default_nettype none
// ============================================================================
// Module : iperf_client_hls_deadlock_monitor_unit
// Brief  : Per-process dataflow deadlock detector with confirm filter,
//          sticky report, event counter and report-token timeout.
// Rev    : 1.0  initial release
// ============================================================================
module iperf_client_hls_deadlock_monitor_unit #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 4,
  parameter int CNT_W          = 8,
  parameter int TOKEN_TIMEOUT  = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [OUT_CHAN_NUM-1:0]       proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]        in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]        token_in_vec,
  input  logic                          dl_detect_in,
  input  logic                          origin,
  input  logic                          token_clear,
  input  logic                          report_ack,
  output logic [OUT_CHAN_NUM-1:0]       out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]           out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]       token_out_vec,
  output logic                          dl_detect_out,
  output logic                          dl_sticky,
  output logic [CNT_W-1:0]              dl_count,
  output logic [IN_CHAN_NUM-1:0]        dl_chan_mask,
  output logic                          token_timeout
);

  localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int TO_W   = (TOKEN_TIMEOUT > 0) ? $clog2(TOKEN_TIMEOUT + 1) : 1;
  localparam logic [CONF_W-1:0]   CONF_MAX = CONF_W'(CONFIRM_CYCLES);
  localparam logic [TO_W-1:0]     TO_MAX   = TO_W'(TOKEN_TIMEOUT);
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [CONF_W-1:0]       r_conf_cnt;
  logic [CONF_W-1:0]       w_conf_nxt;
  logic [PROC_NUM-1:0]     r_dep;
  logic [PROC_NUM-1:0]     w_dep_comb;
  logic [PROC_NUM-1:0]     w_dep;
  logic [IN_CHAN_NUM-1:0]  w_self_mask;
  logic [OUT_CHAN_NUM-1:0] r_token_out;
  logic                    r_sticky;
  logic [CNT_W-1:0]        r_count;
  logic [IN_CHAN_NUM-1:0]  r_chan_mask;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    w_enable;
  logic                    w_blocked;
  logic                    w_cand;
  logic                    w_enter_report;
  logic                    w_report;

  // Merge dependency sets of all valid incoming channels; also note which
  // channels carry our own bit, i.e. which ones close the cycle.
  always_comb begin
    w_dep_comb  = '0;
    w_self_mask = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec[i]) begin
        w_dep_comb = w_dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end
      w_self_mask[i] = in_chan_dep_vld_vec[i] & in_chan_dep_data_vec[i*PROC_NUM + PROC_ID];
    end
  end

  // Once a deadlock is globally flagged, the propagated set freezes until a token arrives.
  assign w_enable  = ~dl_detect_in | (|token_in_vec);
  assign w_dep     = w_enable ? w_dep_comb : r_dep;
  assign w_blocked = |proc_dep_vld_vec;
  assign w_cand    = w_enable & w_dep[PROC_ID] & w_blocked;

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = r_dep | SELF_BIT;
  assign token_out_vec        = r_token_out;
  assign dl_sticky            = r_sticky;
  assign dl_count             = r_count;
  assign dl_chan_mask         = r_chan_mask;
  assign token_timeout        = (TOKEN_TIMEOUT != 0) && (r_to_cnt == TO_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_conf_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_conf_cnt <= w_conf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_conf_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_cand) begin
          if (CONFIRM_CYCLES <= 1) begin
            w_state_nxt = S_REPORT;
          end else begin
            w_state_nxt = S_CONFIRM;
            w_conf_nxt  = CONF_W'(1);
          end
        end
      end
      S_CONFIRM: begin
        if (w_cand) begin
          w_conf_nxt = r_conf_cnt + CONF_W'(1);
          if (w_conf_nxt == CONF_MAX) begin
            w_state_nxt = S_REPORT;
            w_conf_nxt  = '0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REPORT: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!r_sticky && !w_cand) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_report       = (r_state == S_REPORT);
    w_enter_report = (w_state_nxt == S_REPORT) && (r_state != S_REPORT);
    dl_detect_out  = w_report;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dep       <= '0;
      r_token_out <= '0;
      r_sticky    <= 1'b0;
      r_count     <= '0;
      r_chan_mask <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_dep       <= w_blocked ? w_dep : '0;
      r_token_out <= (((|token_in_vec) & ~token_clear) | origin) ? proc_dep_vld_vec : '0;
      // A new report wins over a coincident acknowledge.
      if (w_enter_report) begin
        r_sticky    <= 1'b1;
        r_chan_mask <= w_self_mask;
        if (r_count != {CNT_W{1'b1}}) begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (report_ack) begin
        r_sticky <= 1'b0;
      end
      if (dl_detect_in && !(|token_in_vec)) begin
        if (r_to_cnt != TO_MAX) begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iperf_client_hls_deadlock_monitor_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_iperf_client_hls_deadlock_monitor_unit
// Brief  : Directed scoreboard bench for the deadlock monitor unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_iperf_client_hls_deadlock_monitor_unit;

  localparam int PROC_NUM = 4;
  localparam int IN_CHAN_NUM = 2;
  localparam int OUT_CHAN_NUM = 3;
  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic reset;
  logic [OUT_CHAN_NUM-1:0] proc_dep_vld_vec;
  logic [IN_CHAN_NUM-1:0]  in_chan_dep_vld_vec;
  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
  logic [IN_CHAN_NUM-1:0]  token_in_vec;
  logic dl_detect_in, origin, token_clear, report_ack;
  logic [OUT_CHAN_NUM-1:0] out_chan_dep_vld_vec;
  logic [PROC_NUM-1:0]     out_chan_dep_data;
  logic [OUT_CHAN_NUM-1:0] token_out_vec;
  logic dl_detect_out, dl_sticky, token_timeout;
  logic [CNT_W-1:0]        dl_count;
  logic [IN_CHAN_NUM-1:0]  dl_chan_mask;

  iperf_client_hls_deadlock_monitor_unit #(
    .PROC_NUM(PROC_NUM), .PROC_ID(0), .IN_CHAN_NUM(IN_CHAN_NUM),
    .OUT_CHAN_NUM(OUT_CHAN_NUM), .CONFIRM_CYCLES(4), .CNT_W(CNT_W),
    .TOKEN_TIMEOUT(64)
  ) dut (
    .clock(clock), .reset(reset),
    .proc_dep_vld_vec(proc_dep_vld_vec),
    .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
    .in_chan_dep_data_vec(in_chan_dep_data_vec),
    .token_in_vec(token_in_vec), .dl_detect_in(dl_detect_in),
    .origin(origin), .token_clear(token_clear), .report_ack(report_ack),
    .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
    .out_chan_dep_data(out_chan_dep_data),
    .token_out_vec(token_out_vec), .dl_detect_out(dl_detect_out),
    .dl_sticky(dl_sticky), .dl_count(dl_count),
    .dl_chan_mask(dl_chan_mask), .token_timeout(token_timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  string       tq[$];
  logic [31:0] eq[$];

  task automatic expect_v(input string t, input logic [31:0] e);
    tq.push_back(t);
    eq.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    checks++;
    if (eq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      t = tq.pop_front();
      e = eq.pop_front();
      assert (obs === e) else begin
        errors++;
        $display("FAIL %s observed=%0h expected=%0h", t, obs, e);
        $error("%s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic stim_on();
    in_chan_dep_vld_vec  = 2'b11;
    in_chan_dep_data_vec = 8'h21;
    proc_dep_vld_vec     = 3'b001;
  endtask

  task automatic stim_off();
    in_chan_dep_vld_vec  = '0;
    in_chan_dep_data_vec = '0;
    proc_dep_vld_vec     = '0;
  endtask

  task automatic episode(input bit do_ack, output int pulses);
    pulses = 0;
    stim_on();
    repeat (4) begin
      tick();
      if (dl_detect_out) pulses++;
    end
    stim_off();
    report_ack = do_ack;
    repeat (2) begin
      tick();
      if (dl_detect_out) pulses++;
    end
    report_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired observed=1 expected=0");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int total;
    reset = 1'b0;
    stim_off();
    token_in_vec = '0;
    dl_detect_in = 1'b0;
    origin = 1'b0;
    token_clear = 1'b0;
    report_ack = 1'b0;
    repeat (2) tick();

    expect_v("rst_detect", 0);  check_v(dl_detect_out);
    expect_v("rst_sticky", 0);  check_v(dl_sticky);
    expect_v("rst_count", 0);   check_v(dl_count);
    expect_v("rst_mask", 0);    check_v(dl_chan_mask);
    expect_v("rst_tmo", 0);     check_v(token_timeout);
    expect_v("rst_tok", 0);     check_v(token_out_vec);
    expect_v("rst_data", 4'b0001); check_v(out_chan_dep_data);
    proc_dep_vld_vec = 3'b110;
    #1;
    expect_v("vld_pass", 3'b110); check_v(out_chan_dep_vld_vec);
    proc_dep_vld_vec = '0;
    reset = 1'b1;

    // Cycle present for only three edges: filtered out.
    stim_on();
    for (int k = 1; k <= 3; k++) begin
      expect_v("short_detect", 0); tick(); check_v(dl_detect_out);
    end
    stim_off();
    expect_v("short_drop_detect", 0); tick(); check_v(dl_detect_out);
    expect_v("short_count", 0); check_v(dl_count);

    // Confirmed cycle: pulse right after the 4th edge.
    stim_on();
    for (int k = 1; k <= 4; k++) begin
      expect_v("confirm_detect", (k == 4) ? 1 : 0); tick(); check_v(dl_detect_out);
    end
    expect_v("confirm_count", 1);   check_v(dl_count);
    expect_v("confirm_sticky", 1);  check_v(dl_sticky);
    expect_v("confirm_mask", 2'b01); check_v(dl_chan_mask);
    expect_v("confirm_data", 4'b0011); check_v(out_chan_dep_data);

    // Held to cycle 20 with ack at cycle 10: no further pulses.
    total = 0;
    for (int k = 5; k <= 20; k++) begin
      report_ack = (k == 10);
      tick();
      if (dl_detect_out) total++;
      if (k == 9)  begin expect_v("hold_sticky_pre_ack", 1); check_v(dl_sticky); end
      if (k == 10) begin expect_v("hold_sticky_post_ack", 0); check_v(dl_sticky); end
    end
    report_ack = 1'b0;
    expect_v("hold_extra_pulses", 0); check_v(total);
    stim_off();
    tick();
    episode(1'b1, p);
    expect_v("second_pulses", 1); check_v(p);
    expect_v("second_count", 2);  check_v(dl_count);

    // Token timeout and forwarding.
    dl_detect_in = 1'b1;
    proc_dep_vld_vec = 3'b101;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) begin expect_v("tmo_63", 0); check_v(token_timeout); end
      if (k == 64) begin expect_v("tmo_64", 1); check_v(token_timeout); end
    end
    expect_v("tok_idle", 0); check_v(token_out_vec);
    token_in_vec = 2'b01;
    tick();
    expect_v("tmo_clear", 0);    check_v(token_timeout);
    expect_v("tok_fwd", 3'b101); check_v(token_out_vec);
    token_clear = 1'b1;
    tick();
    expect_v("tok_cleared", 0);  check_v(token_out_vec);
    token_clear = 1'b0;
    token_in_vec = '0;
    origin = 1'b1;
    tick();
    expect_v("tok_origin", 3'b101); check_v(token_out_vec);
    origin = 1'b0;
    dl_detect_in = 1'b0;
    proc_dep_vld_vec = '0;
    tick();

    // Drive the counter to saturation.
    total = 0;
    for (int n = 0; n < 253; n++) begin
      episode(1'b1, p);
      total += p;
    end
    expect_v("sat_pulses", 253); check_v(total);
    expect_v("sat_count_255", 255); check_v(dl_count);
    episode(1'b0, p);
    expect_v("sat_last_pulse", 1); check_v(p);
    expect_v("sat_count_hold", 255); check_v(dl_count);
    expect_v("sat_sticky", 1); check_v(dl_sticky);

    // Asynchronous reset while in HOLD.
    #2 reset = 1'b0;
    #1;
    expect_v("arst_count", 0);  check_v(dl_count);
    expect_v("arst_sticky", 0); check_v(dl_sticky);
    expect_v("arst_mask", 0);   check_v(dl_chan_mask);
    tick();
    reset = 1'b1;

    // Asynchronous reset at confirm count 2, then a fresh confirm window.
    stim_on();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    expect_v("arst2_detect", 0); check_v(dl_detect_out);
    expect_v("arst2_data", 4'b0001); check_v(out_chan_dep_data);
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expect_v("fresh_detect", (k == 4) ? 1 : 0); tick(); check_v(dl_detect_out);
    end
    expect_v("fresh_count", 1); check_v(dl_count);
    stim_off();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
